// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU request unit.
//   word_t     : 32-bit machine word
//   reqstate_t : request sequencer states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IFETCH = 2'd0,
    EXEC   = 2'd1,
    DMEM   = 2'd2,
    HALTED = 2'd3
  } reqstate_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter for a pending memory request.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : clear count (request phase entered)
//   inc_i  : count one more cycle without acknowledge
//   tc_o   : count has reached WAIT_MAX-1 (last permitted wait cycle)
module wait_timer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(WAIT_MAX - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      // Saturate at terminal count; the sequencer leaves the phase there anyway.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/request_unit.sv
// Request unit: sequences instruction fetch, execute and data memory access for a
// multicycle CPU, with a per-request wait timeout.
// Ports:
//   CLK, RST         : clock, synchronous active-high reset
//   iREN/dREN/dWEN   : fetch / load / store requests from control unit
//   halt             : halt request from control unit
//   ihit/dhit        : instruction / data memory acknowledges
//   iload            : instruction word from instruction memory
//   imemREN, dmemREN, dmemWEN : memory strobes
//   pc_en            : one-cycle retire pulse
//   instr            : latched instruction
//   halted, timeout  : sticky stop flags
//   retired          : count of retired instructions (wraps)
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        halt,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic [31:0] instr,
  output logic        halted,
  output logic        timeout,
  output logic [31:0] retired
);

  reqstate_t state_q, state_d;
  word_t     instr_q;
  word_t     retired_q;
  logic      timeout_q;
  logic      timeout_set;
  logic      tmr_clr, tmr_inc, tmr_tc;

  // Counter restarts on every phase change, so entry to IFETCH/DMEM sees zero.
  assign tmr_clr = (state_d != state_q);
  assign tmr_inc = ((state_q == IFETCH) && !ihit) || ((state_q == DMEM) && !dhit);

  wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(tmr_clr),
    .inc_i(tmr_inc),
    .tc_o (tmr_tc)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IFETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      IFETCH: begin
        if (ihit) begin
          state_d = EXEC;
        end else if (tmr_tc) begin
          state_d     = HALTED;
          timeout_set = 1'b1;
        end
      end
      EXEC: begin
        // Priority: halt, illegal load+store, memory op, plain.
        if (halt || (dREN && dWEN)) begin
          state_d = HALTED;
        end else if (dREN || dWEN) begin
          state_d = DMEM;
        end else begin
          state_d = IFETCH;
        end
      end
      DMEM: begin
        if (dhit) begin
          state_d = IFETCH;
        end else if (tmr_tc) begin
          state_d     = HALTED;
          timeout_set = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  // Outputs; everything forced quiet while RST is asserted so an abandoned
  // request never strobes or retires.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pc_en   = 1'b0;
    if (!RST) begin
      unique case (state_q)
        IFETCH: imemREN = iREN;
        EXEC:   pc_en   = !halt && !dREN && !dWEN;
        DMEM: begin
          dmemREN = dREN;
          dmemWEN = dWEN;
          pc_en   = dhit;
        end
        HALTED:  ;
        default: ;
      endcase
    end
  end

  assign halted  = (state_q == HALTED);
  assign instr   = instr_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q   <= '0;
      retired_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == IFETCH) && ihit) begin
        instr_q <= iload;
      end
      if (pc_en) begin
        retired_q <= retired_q + 32'd1;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the request sequencing.
module tb_request_unit;

  localparam int unsigned WaitMax = 4;

  // Model phases
  localparam int PhFetch = 0;
  localparam int PhExec  = 1;
  localparam int PhMem   = 2;
  localparam int PhStop  = 3;

  logic        clk = 1'b0;
  logic        rst, iren, dren, dwen, hlt, ihit, dhit;
  logic [31:0] iload;
  logic        imem_ren, dmem_ren, dmem_wen, pc_en, halted, timeout;
  logic [31:0] instr, retired;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int          m_ph;
  int          m_waited;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  bit          m_to;

  always #5 clk = ~clk;

  request_unit #(
    .WAIT_MAX(WaitMax)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .iREN   (iren),
    .dREN   (dren),
    .dWEN   (dwen),
    .halt   (hlt),
    .ihit   (ihit),
    .dhit   (dhit),
    .iload  (iload),
    .imemREN(imem_ren),
    .dmemREN(dmem_ren),
    .dmemWEN(dmem_wen),
    .pc_en  (pc_en),
    .instr  (instr),
    .halted (halted),
    .timeout(timeout),
    .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph     = PhFetch;
    m_waited = 0;
    m_instr  = '0;
    m_ret    = '0;
    m_to     = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit r, input bit ir, input bit dr, input bit dw, input bit hl,
                      input bit ih, input bit dh, input logic [31:0] il);
    bit e_imem, e_dren, e_dwen, e_pc;
    rst = r; iren = ir; dren = dr; dwen = dw; hlt = hl; ihit = ih; dhit = dh; iload = il;
    #4;
    e_imem = 1'b0; e_dren = 1'b0; e_dwen = 1'b0; e_pc = 1'b0;
    if (!r) begin
      if (m_ph == PhFetch) e_imem = ir;
      if (m_ph == PhExec)  e_pc   = !hl && !dr && !dw;
      if (m_ph == PhMem) begin
        e_dren = dr;
        e_dwen = dw;
        e_pc   = dh;
      end
    end
    check_eq("imemREN", imem_ren, e_imem);
    check_eq("dmemREN", dmem_ren, e_dren);
    check_eq("dmemWEN", dmem_wen, e_dwen);
    check_eq("pc_en",   pc_en,    e_pc);
    check_eq("halted",  halted,   m_ph == PhStop);
    check_eq("timeout", timeout,  m_to);
    check_eq("instr",   instr,    m_instr);
    check_eq("retired", retired,  m_ret);
    if (r) begin
      model_reset();
    end else begin
      if (e_pc) m_ret = m_ret + 1;
      case (m_ph)
        PhFetch: begin
          if (ih) begin
            m_instr = il;
            m_ph    = PhExec;
          end else if (m_waited + 1 == WaitMax) begin
            m_ph = PhStop;
            m_to = 1'b1;
          end else begin
            m_waited++;
          end
        end
        PhExec: begin
          m_waited = 0;
          if (hl || (dr && dw))  m_ph = PhStop;
          else if (dr || dw)     m_ph = PhMem;
          else                   m_ph = PhFetch;
        end
        PhMem: begin
          if (dh) begin
            m_ph     = PhFetch;
            m_waited = 0;
          end else if (m_waited + 1 == WaitMax) begin
            m_ph = PhStop;
            m_to = 1'b1;
          end else begin
            m_waited++;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit r;
    rst = 1'b1; iren = 0; dren = 0; dwen = 0; hlt = 0; ihit = 0; dhit = 0; iload = '0;
    @(posedge clk);
    #1;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_retired", retired, 32'h0);
    check_eq("rst_halted", halted, 1'b0);

    // ADDU: immediate ihit, then one EXEC cycle retires
    step(0, 1, 0, 0, 0, 1, 0, 32'h0123_4021);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_eq("addu_retired", retired, 32'd1);
    check_eq("addu_instr", instr, 32'h0123_4021);

    // LW: dhit on the fourth DMEM cycle
    step(0, 1, 0, 0, 0, 1, 0, 32'h8c22_0004);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 1, 32'h0);
    check_eq("lw_retired", retired, 32'd2);

    // Illegal load+store in EXEC
    step(0, 1, 0, 0, 0, 1, 0, 32'hdead_0001);
    step(0, 0, 1, 1, 0, 0, 1, 32'h0);
    check_eq("illegal_halted", halted, 1'b1);
    check_eq("illegal_timeout", timeout, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // HALT with a memory request also asserted; sticky through random inputs
    step(0, 1, 0, 0, 0, 1, 0, 32'hfc00_0000);
    step(0, 0, 1, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom);
    check_eq("halt_sticky", halted, 1'b1);
    check_eq("halt_retired", retired, 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Fetch timeout after WaitMax cycles without ihit
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_eq("to_halted", halted, 1'b1);
    check_eq("to_timeout", timeout, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    // ihit on the last permitted cycle wins
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 1, 0, 32'h0000_5555);
    check_eq("late_hit_halted", halted, 1'b0);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_eq("late_hit_retired", retired, 32'd1);

    // Reset during a store wait abandons it
    step(0, 1, 0, 0, 0, 1, 0, 32'hac01_0008);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 0, 0, 1, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_eq("rstmid_retired", retired, 32'd0);
    check_eq("rstmid_instr", instr, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = ((m_ph == PhStop) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 63) == 0);
      step(r, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 The module SHALL have parameter WAIT_MAX, default 255: maximum cycles a memory request waits for its hit before timeout.
REQ-002 The module SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 The module SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port iREN  input  1  instruction read request from control unit.
REQ-005 The module SHALL have port dREN  input  1  data read request from control unit (load).
REQ-006 The module SHALL have port dWEN  input  1  data write request from control unit (store).
REQ-007 The module SHALL have port halt  input  1  halt request from control unit (HALT opcode or overflow).
REQ-008 The module SHALL have port ihit  input  1  instruction memory acknowledge, iload valid this cycle.
REQ-009 The module SHALL have port dhit  input  1  data memory acknowledge.
REQ-010 The module SHALL have port iload  input  32  instruction word from instruction memory.
REQ-011 The module SHALL have port imemREN  output  1  instruction memory read strobe.
REQ-012 The module SHALL have port dmemREN  output  1  data memory read strobe.
REQ-013 The module SHALL have port dmemWEN  output  1  data memory write strobe.
REQ-014 The module SHALL have port pc_en  output  1  one-cycle pulse: retire instruction, advance PC, enable register write.
REQ-015 The module SHALL have port instr  output  32  latched instruction driven to control unit and datapath.
REQ-016 The module SHALL have port halted  output  1  sticky stop indication.
REQ-017 The module SHALL have port timeout  output  1  sticky flag: halted because a request exceeded WAIT_MAX.
REQ-018 The module SHALL have port retired  output  32  count of pc_en pulses since reset, wraps modulo 2^32.

Function
REQ-019 The FSM SHALL have states IFETCH, EXEC, DMEM, HALTED; all outputs decoded from registered state.
REQ-020 IFETCH SHALL drive imemREN=iREN; on ihit=1 it SHALL latch iload into instr and go to EXEC next cycle.
REQ-021 EXEC SHALL last exactly one cycle, evaluating control inputs decoded from instr, priority: halt, then illegal, then memory, then plain.
REQ-022 EXEC with halt=1 SHALL go to HALTED with no memory strobe and no pc_en, even if dREN/dWEN=1.
REQ-023 EXEC with dREN=1 and dWEN=1 together SHALL be illegal: go to HALTED, timeout stays 0.
REQ-024 EXEC with exactly one of dREN/dWEN SHALL go to DMEM; otherwise it SHALL pulse pc_en and return to IFETCH.
REQ-025 DMEM SHALL hold dmemREN=dREN and dmemWEN=dWEN until dhit=1; on dhit it SHALL pulse pc_en the same cycle and go to IFETCH.
REQ-026 Register-only instruction latency SHALL be 2 cycles minimum (IFETCH with immediate ihit, EXEC); load/store 3 cycles minimum.
REQ-027 ihit outside IFETCH and dhit outside DMEM SHALL be ignored.
REQ-028 A wait counter SHALL clear on entry to IFETCH/DMEM and increment each cycle without the relevant hit.
REQ-029 When the counter equals WAIT_MAX-1 with no hit, next state SHALL be HALTED with timeout=1; a hit on that same cycle wins.
REQ-030 HALTED SHALL drive all strobes and pc_en to 0, halted=1, and be left only by RST.
REQ-031 retired SHALL increment by 1 on every pc_en pulse and hold otherwise.

Reset
REQ-032 While RST=1 at a clock edge, state SHALL become IFETCH, instr=0, wait counter=0, retired=0, halted=0, timeout=0.
REQ-033 RST mid-request SHALL abandon it without pc_en; strobes SHALL be 0 during reset cycles and imemREN SHALL be 1 in the first cycle after RST falls.

Structure
REQ-034 Package cpu_types_pkg SHALL hold the reqstate_t enum and word_t (32-bit); WAIT_MAX stays a module parameter.
REQ-035 The wait counter with its terminal-count compare SHALL be a sub-module named wait_timer, width clog2(WAIT_MAX).

Verification
REQ-036 ADDU, ihit immediate -> imemREN 1 cycle, EXEC, pc_en 1 cycle on cycle 2, retired=1.
REQ-037 LW, dhit after 3 cycles -> dmemREN high 4 cycles, pc_en on the dhit cycle, dmemWEN=0 throughout.
REQ-038 HALT opcode (or ADD with overflow) in EXEC -> halted=1 next cycle, no pc_en, no strobes, sticky over 10 cycles.
REQ-039 WAIT_MAX=4, ihit never asserted -> HALTED after 4 IFETCH cycles, timeout=1; repeat with ihit on 4th cycle -> normal EXEC.
REQ-040 RST pulsed during DMEM wait -> no pc_en, retired=0, instr=0, imemREN=1 first cycle after release.
REQ-041 dREN=1 and dWEN=1 forced in EXEC -> HALTED, timeout=0, no strobe.
